snake_engine: RTL and testbench
===============================

Name: snake_engine

Overview:
- Game-state and pixel-render stage directly downstream of the 640x480 VGA timing generator.
- Consumes pos_x/pos_y/hsync/vsync/data_en and produces registered 12-bit RGB plus sync delayed to match.
- Holds snake body, food, direction, score and game FSM; updates the snake on a 40x30 grid of 16x16-px cells once every STEP_FRAMES frames, during vertical blank.

Parameters:
- MAX_LEN, 16, segment storage depth (max snake length, 2..32)
- INIT_LEN, 3, length after reset/restart (2..MAX_LEN)
- STEP_FRAMES, 8, frames per snake move (>=1)
- LFSR_SEED, 16'hACE1, food LFSR reset value (non-zero)

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- pos_x  in  10  current pixel column from timing generator
- pos_y  in  10  current pixel row
- hsync_in / vsync_in / de_in  in  1 each  sync and data-enable from timing generator
- btn_up / btn_down / btn_left / btn_right / btn_start  in  1 each  level, synchronised and debounced upstream
- vga_r / vga_g / vga_b  out  4 each  registered colour
- hsync_out / vsync_out  out  1 each  sync delayed 1 clk
- score  out  8  food eaten, saturates at 255
- game_over  out  1  high in OVER state

Behaviour:
- Reset (sync, active-high; clk) is the only reset.
- Reset values:
  - rgb 0; hsync_out = vsync_out = 1; game_over 0; score 0; state IDLE
  - snake len = INIT_LEN; seg[0] = head (20,15), seg[i] = (20-i,15); dir RIGHT; food (30,15); lfsr = LFSR_SEED
- Cells: cx = pos_x[9:4] (0..39), cy = pos_y[9:4] (0..29). Segment x is 6 bits, y is 5 bits.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clk.
- Frame tick: one-cycle pulse when pos_x==0 and pos_y==480.
- Step counter: counts ticks in RUN only; at STEP_FRAMES-1, wraps to 0 and enters MOVE. Cleared on entering RUN.
- Direction request:
  - In RUN, pending_dir loads from buttons; priority up>down>left>right.
  - A request opposite to the committed dir is ignored.
  - Committed dir <= pending_dir at MOVE.
- FSM:
  - IDLE: rising edge of btn_start (edge vs previous-cycle value) -> RUN.
  - RUN: step expiry -> MOVE.
  - MOVE (1 cycle): compute new head from committed dir, then:
    - Wall: x=0 moving left, x=39 right, y=0 up, y=29 down -> OVER, body unchanged.
    - eat = (new head == food).
    - Self-collision: new head == seg[i] for i < len-1 (eat=0) or i < len (eat=1) -> OVER, body unchanged.
    - Otherwise: seg[i] <= seg[i-1], seg[0] <= new head.
    - If eat: len <= min(len+1, MAX_LEN), score <= sat(score+1), go PLACE. Else go RUN.
  - PLACE:
    - Candidate fx = lfsr[5:0] (minus 40 if >=40), fy = lfsr[12:8] (minus 30 if >=30).
    - If candidate matches any seg[i], i<len, stay in PLACE and retry next cycle; else commit food, go RUN.
    - Ticks during PLACE are not counted.
  - OVER: game_over=1. btn_start rising edge -> reload initial snake/dir/food/len, score 0 -> RUN. LFSR is not reloaded.
- Render (1-cycle latency):
  - Registered outputs reflect pos/de at previous cycle; hsync_out/vsync_out are hsync_in/vsync_in delayed 1 clk.
  - Priority:
    - de_in=0 -> 000
    - head cell -> FF0
    - body cell (1 <= i < len) -> 0F0
    - food cell -> F00
    - else 400 in OVER, 000 otherwise
  - Segments at i >= len are ignored.
- Body state changes only in MOVE/PLACE. These are entered from ticks at vblank start, so no tearing.
- Reset mid-game or mid-PLACE returns immediately to reset values.

Test Plan:
- Reset, drive pos (320,240) de=1 -> next cycle rgb=FF0. Pos (304,240) -> 0F0. Pos (480,240) -> F00. de=0 -> 000. hsync_out/vsync_out = inputs delayed 1.
- STEP_FRAMES=1, start pulse, one tick -> head (21,15), seg[2]=(19,15), score 0, state RUN.
- In RUN with dir RIGHT, hold btn_left, tick -> head continues to (22,15). Then btn_up, tick -> head (22,14).
- Steer head into food at (30,15) -> score=1, len=4, PLACE ends with food off all segments, then RUN.
- Run right from (20,15) through x=39, one more tick -> game_over=1, head stays (39,15), background 400. btn_start rising edge -> head (20,15), score 0, game_over 0.
- Assert reset during PLACE -> next cycle state IDLE, score 0, rgb 0, len INIT_LEN.

Source files
------------

// File: rtl/snake_engine.sv
// snake_engine: game state and pixel render stage for a 640x480 VGA pipeline.
//
// Sits directly after the VGA timing generator. It keeps the snake body,
// food, direction, score and game FSM, and moves the snake on a 40x30 grid
// of 16x16-pixel cells once every STEP_FRAMES frames. The frame tick falls
// at the start of vertical blank, so the body never changes mid-frame.
//
// Ports:
//   clk, reset             pixel clock, synchronous active-high reset
//   pos_x, pos_y           current pixel column / row from timing generator
//   hsync_in, vsync_in     syncs from timing generator
//   de_in                  data enable (visible area)
//   btn_up/down/left/right direction buttons (level, debounced upstream)
//   btn_start              start / restart (rising edge)
//   vga_r, vga_g, vga_b    registered 4-bit colour, 1 clk latency
//   hsync_out, vsync_out   syncs delayed 1 clk to line up with colour
//   score                  food eaten, saturating at 255
//   game_over              high while in the OVER state
module snake_engine #(
    parameter int          MAX_LEN     = 16,
    parameter int          INIT_LEN    = 3,
    parameter int          STEP_FRAMES = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       de_in,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_start,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [7:0] score,
    output logic       game_over
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_MOVE, S_PLACE, S_OVER} state_t;
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    function automatic dir_t f_opp(input dir_t d);
        case (d)
            D_UP:    return D_DOWN;
            D_DOWN:  return D_UP;
            D_LEFT:  return D_RIGHT;
            default: return D_LEFT;
        endcase
    endfunction

    // ---------------- state ----------------
    state_t        r_state;
    dir_t          r_dir;
    dir_t          r_pend_dir;
    logic [5:0]    r_seg_x [MAX_LEN];
    logic [4:0]    r_seg_y [MAX_LEN];
    logic [LW-1:0] r_len;
    logic [5:0]    r_food_x;
    logic [4:0]    r_food_y;
    logic [7:0]    r_score;
    logic          r_game_over;
    logic [CW-1:0] r_step;
    logic [15:0]   r_lfsr;
    logic          r_start_q;
    logic [11:0]   r_rgb;
    logic          r_hs;
    logic          r_vs;

    // ---------------- combinational helpers ----------------
    logic          w_tick;
    logic          w_start_rise;
    logic          w_restart;
    logic          w_req_vld;
    dir_t          w_req_dir;
    logic          w_req_ok;
    logic [5:0]    w_nx;
    logic [4:0]    w_ny;
    logic          w_wall;
    logic          w_eat;
    logic [LW-1:0] w_lim;
    logic          w_self;
    logic [5:0]    w_fx;
    logic [4:0]    w_fy;
    logic          w_fhit;
    logic [5:0]    w_cx;
    logic [5:0]    w_cy;
    logic          w_head_hit;
    logic          w_body_hit;
    logic          w_food_hit;
    logic          w_lfsr_fb;

    assign w_tick       = (pos_x == 10'd0) && (pos_y == 10'd480);
    assign w_start_rise = btn_start && !r_start_q;
    assign w_restart    = (r_state == S_OVER) && w_start_rise;
    assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Highest-priority pressed button; a reversal onto the body is dropped.
    always_comb begin
        w_req_vld = 1'b1;
        w_req_dir = D_RIGHT;
        if (btn_up)         w_req_dir = D_UP;
        else if (btn_down)  w_req_dir = D_DOWN;
        else if (btn_left)  w_req_dir = D_LEFT;
        else if (btn_right) w_req_dir = D_RIGHT;
        else                w_req_vld = 1'b0;
    end
    assign w_req_ok = w_req_vld && (w_req_dir != f_opp(r_dir));

    // Next head uses the pending direction, which is committed in MOVE.
    always_comb begin
        w_nx   = r_seg_x[0];
        w_ny   = r_seg_y[0];
        w_wall = 1'b0;
        case (r_pend_dir)
            D_UP:    begin w_wall = (r_seg_y[0] == 5'd0);  w_ny = r_seg_y[0] - 5'd1; end
            D_DOWN:  begin w_wall = (r_seg_y[0] == 5'd29); w_ny = r_seg_y[0] + 5'd1; end
            D_LEFT:  begin w_wall = (r_seg_x[0] == 6'd0);  w_nx = r_seg_x[0] - 6'd1; end
            default: begin w_wall = (r_seg_x[0] == 6'd39); w_nx = r_seg_x[0] + 6'd1; end
        endcase
    end

    assign w_eat = (w_nx == r_food_x) && (w_ny == r_food_y);
    // Without eating, the tail cell is vacated this step, so it is not a hit.
    assign w_lim = w_eat ? r_len : r_len - LW'(1);

    always_comb begin
        w_self = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (LW'(i) < w_lim && r_seg_x[i] == w_nx && r_seg_y[i] == w_ny)
                w_self = 1'b1;
    end

    // Food candidate folded into grid range.
    assign w_fx = (r_lfsr[5:0] >= 6'd40)  ? r_lfsr[5:0] - 6'd40  : r_lfsr[5:0];
    assign w_fy = (r_lfsr[12:8] >= 5'd30) ? r_lfsr[12:8] - 5'd30 : r_lfsr[12:8];

    always_comb begin
        w_fhit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (LW'(i) < r_len && r_seg_x[i] == w_fx && r_seg_y[i] == w_fy)
                w_fhit = 1'b1;
    end

    // ---------------- game FSM ----------------
    always_ff @(posedge clk) begin
        r_lfsr    <= reset ? LFSR_SEED : {r_lfsr[14:0], w_lfsr_fb};
        r_start_q <= reset ? 1'b0 : btn_start;

        if (reset || w_restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= 6'(20 - i);
                r_seg_y[i] <= 5'd15;
            end
            r_len       <= LW'(INIT_LEN);
            r_dir       <= D_RIGHT;
            r_pend_dir  <= D_RIGHT;
            r_food_x    <= 6'd30;
            r_food_y    <= 5'd15;
            r_score     <= 8'd0;
            r_step      <= '0;
            r_game_over <= 1'b0;
            r_state     <= reset ? S_IDLE : S_RUN;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_rise) begin
                        r_step  <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_req_ok) r_pend_dir <= w_req_dir;
                    if (w_tick) begin
                        if (r_step == CW'(STEP_FRAMES - 1)) begin
                            r_step  <= '0;
                            r_state <= S_MOVE;
                        end else begin
                            r_step <= r_step + CW'(1);
                        end
                    end
                end
                S_MOVE: begin
                    r_dir <= r_pend_dir;
                    if (w_wall || w_self) begin
                        r_game_over <= 1'b1;
                        r_state     <= S_OVER;
                    end else begin
                        for (int i = 1; i < MAX_LEN; i++) begin
                            r_seg_x[i] <= r_seg_x[i-1];
                            r_seg_y[i] <= r_seg_y[i-1];
                        end
                        r_seg_x[0] <= w_nx;
                        r_seg_y[0] <= w_ny;
                        r_step     <= '0;
                        if (w_eat) begin
                            if (r_len != LW'(MAX_LEN)) r_len <= r_len + LW'(1);
                            if (r_score != 8'hFF)      r_score <= r_score + 8'd1;
                            r_state <= S_PLACE;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_PLACE: begin
                    // Retry with the next LFSR value until the cell is free.
                    if (!w_fhit) begin
                        r_food_x <= w_fx;
                        r_food_y <= w_fy;
                        r_step   <= '0;
                        r_state  <= S_RUN;
                    end
                end
                default: ;  // S_OVER waits for restart
            endcase
        end
    end

    // ---------------- render ----------------
    assign w_cx       = pos_x[9:4];
    assign w_cy       = pos_y[9:4];
    assign w_head_hit = (w_cx == r_seg_x[0]) && (w_cy == {1'b0, r_seg_y[0]});
    assign w_food_hit = (w_cx == r_food_x) && (w_cy == {1'b0, r_food_y});

    always_comb begin
        w_body_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++)
            if (LW'(i) < r_len && w_cx == r_seg_x[i] && w_cy == {1'b0, r_seg_y[i]})
                w_body_hit = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb <= 12'h000;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
        end else begin
            r_hs <= hsync_in;
            r_vs <= vsync_in;
            if (!de_in)                 r_rgb <= 12'h000;
            else if (w_head_hit)        r_rgb <= 12'hFF0;
            else if (w_body_hit)        r_rgb <= 12'h0F0;
            else if (w_food_hit)        r_rgb <= 12'hF00;
            else if (r_state == S_OVER) r_rgb <= 12'h400;
            else                        r_rgb <= 12'h000;
        end
    end

    assign vga_r     = r_rgb[11:8];
    assign vga_g     = r_rgb[7:4];
    assign vga_b     = r_rgb[3:0];
    assign hsync_out = r_hs;
    assign vsync_out = r_vs;
    assign score     = r_score;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: directed checks followed by randomized play,
// compared against a queue-based game model kept in this file.
module tb_snake_engine;
  localparam int SF = 2;
  localparam int ML = 16;
  localparam int IL = 3;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PLACE = 2, ST_OVER = 3;
  localparam int DU = 0, DD = 1, DL = 2, DR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [9:0] pos_x, pos_y;
  logic       hsync_in, vsync_in, de_in;
  logic       btn_up, btn_down, btn_left, btn_right, btn_start;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       hsync_out, vsync_out;
  logic [7:0] score;
  logic       game_over;

  snake_engine #(.MAX_LEN(ML), .INIT_LEN(IL), .STEP_FRAMES(SF), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .pos_x(pos_x), .pos_y(pos_y),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_start(btn_start), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .score(score), .game_over(game_over)
  );

  int n_chk = 0;
  int n_fail = 0;

  // game model
  int qx[$];
  int qy[$];
  int m_fx, m_fy, m_dir, m_pend, m_score, m_state, m_cnt;
  bit m_abort_place;
  logic [15:0] m_lfsr;

  always @(posedge clk)
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int opp(input int d);
    case (d)
      DU: return DD;
      DD: return DU;
      DL: return DR;
      default: return DL;
    endcase
  endfunction

  function automatic bit on_snake(input int x, input int y);
    for (int i = 0; i < qx.size(); i++)
      if (qx[i] == x && qy[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [11:0] exp_rgb(input int x, input int y);
    if (qx[0] == x && qy[0] == y) return 12'hFF0;
    for (int i = 1; i < qx.size(); i++)
      if (qx[i] == x && qy[i] == y) return 12'h0F0;
    if (m_fx == x && m_fy == y) return 12'hF00;
    return (m_state == ST_OVER) ? 12'h400 : 12'h000;
  endfunction

  task automatic model_init();
    qx.delete();
    qy.delete();
    for (int i = 0; i < IL; i++) begin
      qx.push_back(20 - i);
      qy.push_back(15);
    end
    m_fx = 30; m_fy = 15; m_dir = DR; m_pend = DR; m_score = 0; m_cnt = 0;
  endtask

  task automatic rgb_px(input int px, input int py, output logic [11:0] c);
    pos_x = 10'(px); pos_y = 10'(py); de_in = 1'b1;
    cyc();
    c = {vga_r, vga_g, vga_b};
    de_in = 1'b0;
  endtask

  task automatic rgb_at(input int x, input int y, output logic [11:0] c);
    rgb_px(x * 16 + 8, y * 16 + 8, c);
  endtask

  task automatic probe(input string tag, input int x, input int y);
    logic [11:0] c;
    rgb_at(x, y, c);
    chk($sformatf("%s_cell%0d_%0d", tag, x, y), 32'(c), 32'(exp_rgb(x, y)));
  endtask

  task automatic cchk(input string tag, input int x, input int y, input logic [11:0] exp);
    logic [11:0] c;
    rgb_at(x, y, c);
    chk(tag, 32'(c), 32'(exp));
  endtask

  // mask = {up, down, left, right}
  task automatic press(input logic [3:0] m);
    int d;
    {btn_up, btn_down, btn_left, btn_right} = m;
    cyc();
    {btn_up, btn_down, btn_left, btn_right} = 4'b0;
    if (m_state == ST_RUN && m != 4'b0) begin
      d = m[3] ? DU : m[2] ? DD : m[1] ? DL : DR;
      if (d != opp(m_dir)) m_pend = d;
    end
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    cyc();
    btn_start = 1'b0;
    cyc();
    if (m_state == ST_IDLE) begin
      m_state = ST_RUN; m_cnt = 0;
    end else if (m_state == ST_OVER) begin
      model_init();
      m_state = ST_RUN;
    end
  endtask

  task automatic model_place();
    int cx, cy;
    bit done;
    done = 1'b0;
    for (int k = 0; k < 500 && !done; k++) begin
      cx = int'(m_lfsr[5:0]);  if (cx >= 40) cx -= 40;
      cy = int'(m_lfsr[12:8]); if (cy >= 30) cy -= 30;
      cyc();
      if (!on_snake(cx, cy)) begin
        m_fx = cx; m_fy = cy; m_state = ST_RUN; done = 1'b1;
      end
    end
    if (!done) chk("place_bound", 32'd0, 32'd1);
  endtask

  task automatic model_move();
    int nx, ny, lim;
    bit wall, eat, hit;
    m_dir = m_pend;
    nx = qx[0]; ny = qy[0];
    case (m_dir)
      DU:      begin wall = (ny == 0);  ny--; end
      DD:      begin wall = (ny == 29); ny++; end
      DL:      begin wall = (nx == 0);  nx--; end
      default: begin wall = (nx == 39); nx++; end
    endcase
    eat = !wall && nx == m_fx && ny == m_fy;
    lim = eat ? qx.size() : qx.size() - 1;
    hit = 1'b0;
    for (int i = 0; i < lim; i++)
      if (qx[i] == nx && qy[i] == ny) hit = 1'b1;
    cyc();
    if (wall || hit) begin
      m_state = ST_OVER;
      return;
    end
    qx.push_front(nx);
    qy.push_front(ny);
    if (!eat || qx.size() > ML) begin
      void'(qx.pop_back());
      void'(qy.pop_back());
    end
    if (!eat) begin
      m_state = ST_RUN;
      return;
    end
    if (m_score < 255) m_score++;
    m_state = ST_PLACE;
    if (!m_abort_place) model_place();
  endtask

  task automatic tick();
    pos_x = 10'd0; pos_y = 10'd480; de_in = 1'b0;
    cyc();
    pos_x = 10'd700; pos_y = 10'd500;
    if (m_state == ST_RUN) begin
      m_cnt++;
      if (m_cnt == SF) begin
        m_cnt = 0;
        model_move();
      end
    end
  endtask

  task automatic do_move();
    repeat (SF) tick();
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_score"}, 32'(score), 32'(m_score));
    chk({tag, "_over"}, 32'(game_over), 32'(m_state == ST_OVER));
    for (int i = 0; i < qx.size(); i++) probe(tag, qx[i], qy[i]);
    probe(tag, m_fx, m_fy);
    probe(tag, int'($urandom_range(39)), int'($urandom_range(29)));
  endtask

  task automatic full_scan(input string tag);
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 40; x++) probe(tag, x, y);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] c;
    int bx, by;
    reset = 1'b1;
    pos_x = 10'd320; pos_y = 10'd240; de_in = 1'b1;
    hsync_in = 1'b0; vsync_in = 1'b0;
    {btn_up, btn_down, btn_left, btn_right, btn_start} = 5'b0;
    m_abort_place = 1'b0;
    model_init();
    m_state = ST_IDLE;
    repeat (3) cyc();
    chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    chk("rst_hs", 32'(hsync_out), 32'd1);
    chk("rst_vs", 32'(vsync_out), 32'd1);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);
    reset = 1'b0; de_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    cyc();

    // render in IDLE
    rgb_px(320, 240, c); chk("r_head", 32'(c), 32'hFF0);
    rgb_px(304, 240, c); chk("r_body", 32'(c), 32'h0F0);
    rgb_px(480, 240, c); chk("r_food", 32'(c), 32'hF00);
    pos_x = 10'd320; pos_y = 10'd240; de_in = 1'b0;
    cyc(); chk("r_de0", 32'({vga_r, vga_g, vga_b}), 32'h0);
    hsync_in = 1'b0; vsync_in = 1'b1;
    cyc(); chk("sync_hs0", 32'(hsync_out), 32'd0); chk("sync_vs1", 32'(vsync_out), 32'd1);
    hsync_in = 1'b1; vsync_in = 1'b0;
    cyc(); chk("sync_hs1", 32'(hsync_out), 32'd1); chk("sync_vs0", 32'(vsync_out), 32'd0);
    vsync_in = 1'b1;

    // ticks in IDLE do nothing
    do_move();
    cchk("idle_tick_head", 20, 15, 12'hFF0);

    press_start();
    tick();
    cchk("half_step_head", 20, 15, 12'hFF0);
    tick();
    cchk("step1_head", 21, 15, 12'hFF0);
    cchk("step1_seg2", 19, 15, 12'h0F0);
    cchk("step1_tail_gone", 18, 15, 12'h000);
    chk("step1_score", 32'(score), 32'd0);

    press(4'b0010); do_move();
    cchk("rev_ignored", 22, 15, 12'hFF0);
    press(4'b1000); do_move();
    cchk("turn_up", 22, 14, 12'hFF0);
    press(4'b0001); do_move();
    press(4'b0100); do_move();
    cchk("turn_down", 23, 15, 12'hFF0);
    press(4'b0001);
    for (int k = 0; k < 10 && m_score == 0; k++) do_move();
    chk("eat_score", 32'(score), 32'd1);
    cchk("eat_head", 30, 15, 12'hFF0);
    cchk("eat_tail", 27, 15, 12'h0F0);
    full_scan("eat_scan");

    // run into the right wall
    for (int k = 0; k < 20 && m_state != ST_OVER; k++) begin
      do_move();
      check_all("wall_run");
    end
    chk("wall_over", 32'(game_over), 32'd1);
    cchk("wall_head", 39, 15, 12'hFF0);
    bx = 0; by = 0;
    while (on_snake(bx, by) || (bx == m_fx && by == m_fy)) bx++;
    cchk("over_bg", bx, by, 12'h400);

    press_start();
    chk("restart_over", 32'(game_over), 32'd0);
    chk("restart_score", 32'(score), 32'd0);
    cchk("restart_head", 20, 15, 12'hFF0);
    cchk("restart_body", 19, 15, 12'h0F0);
    cchk("restart_food", 30, 15, 12'hF00);

    // reset asserted while food is being placed
    repeat (9) do_move();
    m_abort_place = 1'b1;
    do_move();
    m_abort_place = 1'b0;
    chk("place_score_pre", 32'(score), 32'd1);
    pos_x = 10'd480; pos_y = 10'd240; de_in = 1'b1;
    reset = 1'b1;
    cyc();
    chk("place_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    chk("place_rst_score", 32'(score), 32'd0);
    chk("place_rst_over", 32'(game_over), 32'd0);
    reset = 1'b0; de_in = 1'b0;
    model_init();
    m_state = ST_IDLE;
    cchk("place_rst_head", 20, 15, 12'hFF0);
    cchk("place_rst_len", 17, 15, 12'h000);
    cchk("place_rst_food", 30, 15, 12'hF00);
    do_move();
    cchk("place_rst_idle", 21, 15, 12'h000);

    // randomized play
    for (int g = 0; g < 6; g++) begin
      press_start();
      for (int mv = 0; mv < 60 && m_state != ST_OVER; mv++) begin
        if ($urandom_range(2) == 0) press(4'($urandom_range(15)));
        do_move();
        check_all($sformatf("rnd_g%0d_m%0d", g, mv));
      end
    end
    full_scan("final_scan");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
